// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Registered operand-preparation stage for the ALU adder. It
//               decodes a 3-bit op into {a_mod, b_mod, cin} and has a
//               valid/ready handshake with a 2-entry elastic buffer.
//               Optional accumulator operand source: ALU_OPSTAGE_ACC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_we,
    input  logic [WIDTH-1:0] acc_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_mod,
    output logic [WIDTH-1:0] b_mod,
    output logic             cin
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_ones = '1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;
    logic             r_out_cin;
    logic [WIDTH-1:0] r_skid_a;
    logic [WIDTH-1:0] r_skid_b;
    logic             r_skid_cin;

    logic             w_accept;
    logic             w_load_out;
    logic             w_load_skid;
    logic             w_out_from_skid;
    logic [WIDTH-1:0] w_acc_src;
    logic [WIDTH-1:0] w_dec_a;
    logic [WIDTH-1:0] w_dec_b;
    logic             w_dec_cin;

    assign w_accept = in_valid && r_in_ready;

`ifdef ALU_OPSTAGE_ACC_EN
    logic [WIDTH-1:0] r_acc;

    // Decode reads the pre-write value, so an accept coinciding with acc_we
    // sees the old accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (acc_we) begin
            r_acc <= acc_d;
        end
    end

    assign w_acc_src = r_acc;
`else
    // Without the accumulator, ops 110/111 fall back to ADD/SUB on operand a.
    logic w_unused_acc;
    assign w_unused_acc = ^{acc_we, acc_d};
    assign w_acc_src    = a;
`endif

    always_comb begin
        w_dec_a   = a;
        w_dec_b   = b;
        w_dec_cin = 1'b0;
        case (op)
            3'b000: begin w_dec_a = a;         w_dec_b = b;      w_dec_cin = 1'b0; end
            3'b001: begin w_dec_a = a;         w_dec_b = c_zero; w_dec_cin = 1'b1; end
            3'b010: begin w_dec_a = c_zero;    w_dec_b = ~a;     w_dec_cin = 1'b1; end
            3'b011: begin w_dec_a = a;         w_dec_b = ~b;     w_dec_cin = 1'b1; end
            3'b100: begin w_dec_a = a;         w_dec_b = c_ones; w_dec_cin = 1'b0; end
            3'b101: begin w_dec_a = c_zero;    w_dec_b = b;      w_dec_cin = 1'b0; end
            3'b110: begin w_dec_a = w_acc_src; w_dec_b = b;      w_dec_cin = 1'b0; end
            default: begin w_dec_a = w_acc_src; w_dec_b = ~b;    w_dec_cin = 1'b1; end
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_load_out      = 1'b0;
        w_load_skid     = 1'b0;
        w_out_from_skid = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = S_ONE;
                    w_load_out  = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && out_ready) begin
                    w_load_out  = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = S_FULL;
                    w_load_skid = 1'b1;
                end else if (out_ready) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (out_ready) begin
                    w_state_nxt     = S_ONE;
                    w_out_from_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    // Handshake flags are registered from the next state so neither in_ready
    // nor out_valid has a combinational path from any input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_cin   <= 1'b0;
            r_skid_a    <= '0;
            r_skid_b    <= '0;
            r_skid_cin  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != S_FULL);
            r_out_valid <= (w_state_nxt != S_EMPTY);
            if (w_load_out) begin
                r_out_a   <= w_dec_a;
                r_out_b   <= w_dec_b;
                r_out_cin <= w_dec_cin;
            end else if (w_out_from_skid) begin
                r_out_a   <= r_skid_a;
                r_out_b   <= r_skid_b;
                r_out_cin <= r_skid_cin;
            end
            if (w_load_skid) begin
                r_skid_a   <= w_dec_a;
                r_skid_b   <= w_dec_b;
                r_skid_cin <= w_dec_cin;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign a_mod     = r_out_a;
    assign b_mod     = r_out_b;
    assign cin       = r_out_cin;

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered, parametrised operand-preparation stage for the ALU datapath. Maps a 3-bit operation code onto adder operands `a_mod`, `b_mod` and carry-in `cin`, so one adder serves add, increment, negate, subtract and decrement. Adds a valid/ready handshake with a 2-entry elastic buffer and an optional accumulator operand source. Sits between the instruction/operand source and the ALU adder.

## Interface
- `WIDTH`, default 8: operand width in bits, at least 2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input transaction present.
- `in_ready`  out  1  stage can accept; driven directly from a flop.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `op`  in  3  operation code.
- `acc_we`  in  1  accumulator write enable.
- `acc_d`  in  WIDTH  accumulator write data, normally the ALU result.
- `out_valid`  out  1  prepared operands present.
- `out_ready`  in  1  adder consumes output.
- `a_mod`  out  WIDTH  prepared operand A.
- `b_mod`  out  WIDTH  prepared operand B.
- `cin`  out  1  adder carry-in.

## Operation
- Decode happens at acceptance (`in_valid && in_ready`); the decoded {a_mod, b_mod, cin} is stored, not the raw op.
- 000 ADD: a, b, 0
- 001 INC: a, 0, 1
- 010 NEG: 0, ~a, 1
- 011 SUB: a, ~b, 1
- 100 DEC: a, all-ones, 0
- 101 PASSB: 0, b, 0
- 110 ACCADD: acc, b, 0
- 111 ACCSUB: acc, ~b, 1
- All arithmetic is modulo 2^WIDTH. The stage produces no carry-out; the adder owns it.
- Storage is an output register (OUT) plus one skid entry (SKID). Occupancy states are EMPTY, ONE (OUT full) and FULL (OUT and SKID full).
- EMPTY + accept -> ONE.
- ONE + accept + out_ready -> ONE, with the new data in OUT.
- ONE + accept + !out_ready -> FULL, with the new data in SKID.
- ONE + !accept + out_ready -> EMPTY.
- FULL + out_ready -> ONE, with SKID moving to OUT. No accept is possible in FULL.
- `in_ready` = 1 exactly when the state is not FULL. `out_valid` = 1 exactly when the state is not EMPTY.
- Order is strictly FIFO.
- The accumulator `acc` is WIDTH bits and written with `acc_d` on a cycle where `acc_we` = 1.
- If an accept and `acc_we` occur in the same cycle, the accepted transaction uses the old `acc`. The new value is used from the next accept onward.

## Timing
- Latency is 1 cycle: data accepted at edge N is on the outputs after edge N, provided the state was EMPTY, or ONE with out_ready.
- Sustained throughput is 1 transaction per cycle while `out_ready` = 1.
- Outputs stay stable while `out_valid && !out_ready`.
- Reset values: `in_ready` = 1, `out_valid` = 0, `a_mod` = 0, `b_mod` = 0, `cin` = 0, `acc` = 0, state EMPTY.
- Reset mid-operation discards OUT and SKID contents with no partial output, and takes priority over all other events that cycle.
- No combinational path from any input to `in_ready`.
- `a_mod`, `b_mod`, `cin` and `out_valid` come straight from flops.

## Configuration
- Macro `ALU_OPSTAGE_ACC_EN`.
- Defined: accumulator register, `acc_we`/`acc_d` behaviour and ops 110/111 exactly as in Operation.
- Not defined: no accumulator flops. `acc_we` and `acc_d` stay as ports but are ignored. Op 110 decodes as ADD (a, b, 0) and op 111 as SUB (a, ~b, 1).

## Test plan
- WIDTH=8, out_ready=1, one accept per cycle for SUB a=0x05 b=0x03, then INC a=0xFF, then NEG a=0x01 -> one cycle later, in order: {0x05,0xFC,1}, {0xFF,0x00,1}, {0x00,0xFE,1}; in_ready stays 1.
- out_ready=0, accept DEC a=0x10, then ADD a=0x01 b=0x02 -> state FULL, in_ready=0, outputs hold {0x10,0xFF,0}. Raise out_ready -> {0x10,0xFF,0} then {0x01,0x02,0} on consecutive cycles, in_ready returns to 1 one cycle after the first drain.
- With ALU_OPSTAGE_ACC_EN: acc_we=1 acc_d=0x20, and in the same cycle accept ACCADD b=0x01 -> output {0x00,0x01,0}. Next accept ACCSUB b=0x01 -> {0x20,0xFE,1}.
- Without ALU_OPSTAGE_ACC_EN: op 110 with a=0x07, b=0x02 -> {0x07,0x02,0}, regardless of acc_we.
- FULL state, assert reset for one cycle -> next cycle out_valid=0, in_ready=1, a_mod=b_mod=0, cin=0. The first post-reset accept appears after 1 cycle.
- Random in_valid/out_ready over 1000 transactions -> scoreboard shows no loss, no duplication and FIFO order, with in_ready low only in FULL.
